// File: rtl/arm_mem_arbiter.sv
// Shares one single-ported, variable-latency memory between the instruction
// fetch port and the load/store port. Data accesses have priority over
// fetches. After STARVE_MAX consecutive data grants with a fetch waiting, the
// next grant goes to the fetch. While halt is high, no new fetch is granted.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   halt                     core halted, blocks new fetch grants
//   if_req/if_addr           fetch request, held until if_ack
//   if_rdata/if_ack          fetch completion (combinational, 0 when idle)
//   d_req/d_we/d_addr/d_wdata  data request, held until d_ack
//   d_rdata/d_ack            data completion (combinational, 0 when idle)
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request
//   mem_rdata/mem_ready      memory response
//   owner                    0 = fetch, 1 = data; valid while mem_req
module arm_mem_arbiter #(
   parameter int unsigned ADDR_W     = 30,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              halt,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              owner
);

   localparam int unsigned STREAK_W = 4;
   localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_IF = 2'd1,
      GNT_D  = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [STREAK_W-1:0] streak, streak_nxt;
   logic                mem_req_nxt, mem_we_nxt, owner_nxt;
   logic [ADDR_W-1:0]   mem_addr_nxt;
   logic [DATA_W-1:0]   mem_wdata_nxt;
   logic                if_ok, starved, grant_if, grant_d;

   // State and registered memory-side outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         streak    <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         owner     <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state     <= state_nxt;
         streak    <= streak_nxt;
         mem_req   <= mem_req_nxt;
         mem_we    <= mem_we_nxt;
         owner     <= owner_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
      end
   end

   // Arbitration, grant capture and completion
   always_comb begin
      state_nxt     = state;
      streak_nxt    = streak;
      mem_req_nxt   = mem_req;
      mem_we_nxt    = mem_we;
      owner_nxt     = owner;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      if_ack        = 1'b0;
      d_ack         = 1'b0;
      if_rdata      = '0;
      d_rdata       = '0;
      grant_if      = 1'b0;
      grant_d       = 1'b0;

      if_ok   = if_req & ~halt;
      starved = (streak == STREAK_LIMIT);

      case (state)
         IDLE: begin
            if (if_ok && starved) grant_if = 1'b1;
            else if (d_req)       grant_d  = 1'b1;
            else if (if_ok)       grant_if = 1'b1;
         end
         GNT_IF: begin
            if (mem_ready) begin
               if_ack      = 1'b1;
               if_rdata    = mem_rdata;
               state_nxt   = IDLE;
               mem_req_nxt = 1'b0;
               mem_we_nxt  = 1'b0;
            end
         end
         GNT_D: begin
            if (mem_ready) begin
               d_ack       = 1'b1;
               d_rdata     = mem_rdata;
               state_nxt   = IDLE;
               mem_req_nxt = 1'b0;
               mem_we_nxt  = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (grant_if) begin
         state_nxt     = GNT_IF;
         mem_req_nxt   = 1'b1;
         owner_nxt     = 1'b0;
         mem_we_nxt    = 1'b0;
         mem_addr_nxt  = if_addr;
         mem_wdata_nxt = '0;
         streak_nxt    = '0;
      end

      // Streak counts data grants that overtook a live fetch request
      if (grant_d) begin
         state_nxt     = GNT_D;
         mem_req_nxt   = 1'b1;
         owner_nxt     = 1'b1;
         mem_we_nxt    = d_we;
         mem_addr_nxt  = d_addr;
         mem_wdata_nxt = d_wdata;
         if (!if_ok)       streak_nxt = '0;
         else if (!starved) streak_nxt = streak + STREAK_W'(1);
      end
   end

endmodule

// File: tb/tb_arm_mem_arbiter.sv
module tb_arm_mem_arbiter;

   localparam int unsigned ADDR_W = 30;
   localparam int unsigned DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              halt;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ack;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ack;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   logic              owner;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   arm_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst), .halt(halt),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .owner(owner)
   );

   task automatic test_reset();
      rst = 1'b0; halt = 1'b0; if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      mem_rdata = '0; mem_ready = 1'b0;
      @(negedge clk);
      vectors++;
      if ({mem_req, mem_we, owner, if_ack, d_ack} !== 5'b00000 ||
          mem_addr !== 30'h0 || mem_wdata !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_values: req/we/own/iack/dack=%b%b%b%b%b addr=%h wdata=%h, want 00000 0 0",
                  mem_req, mem_we, owner, if_ack, d_ack, mem_addr, mem_wdata);
      end
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         vectors++;
         if ({mem_req, if_ack, d_ack} !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_cycle%0d: req/iack/dack=%b%b%b, want 000", i, mem_req, if_ack, d_ack);
         end
      end
      // Reset in the middle of a data access
      d_req = 1'b1; d_we = 1'b0; d_addr = 30'h5;
      @(negedge clk);
      vectors++;
      if ({mem_req, owner} !== 2'b11) begin
         miscompares++;
         $display("FAIL pre_reset_grant: req/owner=%b%b, want 11", mem_req, owner);
      end
      #2;
      mem_ready = 1'b1;
      rst = 1'b0;
      #1;
      vectors++;
      if ({mem_req, d_ack} !== 2'b00 || mem_addr !== 30'h0) begin
         miscompares++;
         $display("FAIL reset_mid_access: req/dack=%b%b addr=%h, want 00 0", mem_req, d_ack, mem_addr);
      end
      d_req = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fetch();
      if_req = 1'b1; if_addr = 30'h10;
      @(negedge clk);
      vectors++;
      if ({mem_req, owner, mem_we, if_ack} !== 4'b1000 || mem_addr !== 30'h10 || mem_wdata !== 32'h0) begin
         miscompares++;
         $display("FAIL fetch_grant: req/own/we/ack=%b%b%b%b addr=%h wdata=%h, want 1000 10 0",
                  mem_req, owner, mem_we, if_ack, mem_addr, mem_wdata);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         vectors++;
         if ({mem_req, if_ack} !== 2'b10) begin
            miscompares++;
            $display("FAIL fetch_wait%0d: req/ack=%b%b, want 10", i, mem_req, if_ack);
         end
      end
      @(negedge clk);
      mem_ready = 1'b1; mem_rdata = 32'hE3A01005;
      #1;
      vectors++;
      if (if_ack !== 1'b1 || if_rdata !== 32'hE3A01005 || d_ack !== 1'b0) begin
         miscompares++;
         $display("FAIL fetch_ack: ack=%b rdata=%h dack=%b, want 1 e3a01005 0", if_ack, if_rdata, d_ack);
      end
      if_req = 1'b0;
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      vectors++;
      if ({mem_req, if_ack} !== 2'b00 || if_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL fetch_done: req/ack=%b%b rdata=%h, want 00 0", mem_req, if_ack, if_rdata);
      end
   endtask

   task automatic test_store();
      d_req = 1'b1; d_we = 1'b1; d_addr = 30'h20; d_wdata = 32'hDEADBEEF;
      mem_ready = 1'b1; mem_rdata = 32'h12345678;
      #1;
      vectors++;
      if ({mem_req, d_ack, if_ack} !== 3'b000) begin
         miscompares++;
         $display("FAIL ready_in_idle: req/dack/iack=%b%b%b, want 000", mem_req, d_ack, if_ack);
      end
      @(negedge clk);
      vectors++;
      if ({mem_req, mem_we, owner, d_ack} !== 4'b1111 || mem_addr !== 30'h20 ||
          mem_wdata !== 32'hDEADBEEF || d_rdata !== 32'h12345678) begin
         miscompares++;
         $display("FAIL store_grant: req/we/own/dack=%b%b%b%b addr=%h wdata=%h rdata=%h, want 1111 20 deadbeef 12345678",
                  mem_req, mem_we, owner, d_ack, mem_addr, mem_wdata, d_rdata);
      end
      d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      vectors++;
      if ({mem_req, mem_we, d_ack} !== 3'b000 || d_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL store_done: req/we/dack=%b%b%b rdata=%h, want 000 0", mem_req, mem_we, d_ack, d_rdata);
      end
      mem_ready = 1'b0;
   endtask

   task automatic test_contention();
      logic [9:0] exp_owner;
      exp_owner = 10'b0111101111;   // bit i = owner of grant i (LSB first): D,D,D,D,IF,...
      if_req = 1'b1; if_addr = 30'h40;
      d_req = 1'b1; d_we = 1'b0; d_addr = 30'h50;
      mem_ready = 1'b1; mem_rdata = 32'hA5A5A5A5;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         vectors++;
         if (mem_req !== 1'b1 || owner !== exp_owner[i] ||
             mem_addr !== (exp_owner[i] ? 30'h50 : 30'h40) ||
             d_ack !== exp_owner[i] || if_ack !== !exp_owner[i]) begin
            miscompares++;
            $display("FAIL contention_grant%0d: req=%b owner=%b addr=%h dack=%b iack=%b, want owner %b",
                     i, mem_req, owner, mem_addr, d_ack, if_ack, exp_owner[i]);
         end
         if (i == 9) begin
            if_req = 1'b0; d_req = 1'b0;
         end
         @(negedge clk);
         vectors++;
         if ({mem_req, d_ack, if_ack} !== 3'b000) begin
            miscompares++;
            $display("FAIL contention_idle%0d: req/dack/iack=%b%b%b, want 000", i, mem_req, d_ack, if_ack);
         end
      end
      mem_ready = 1'b0;
   endtask

   task automatic test_halt();
      if_req = 1'b1; if_addr = 30'h60; halt = 1'b0;
      @(negedge clk);
      halt = 1'b1;
      vectors++;
      if ({mem_req, owner} !== 2'b10 || mem_addr !== 30'h60) begin
         miscompares++;
         $display("FAIL halt_fetch_grant: req/owner=%b%b addr=%h, want 10 60", mem_req, owner, mem_addr);
      end
      @(negedge clk);
      mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
      #1;
      vectors++;
      if (if_ack !== 1'b1 || if_rdata !== 32'h0BADF00D) begin
         miscompares++;
         $display("FAIL halt_inflight_ack: ack=%b rdata=%h, want 1 0badf00d", if_ack, if_rdata);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         vectors++;
         if ({mem_req, if_ack} !== 2'b00) begin
            miscompares++;
            $display("FAIL halt_blocks%0d: req/iack=%b%b, want 00", i, mem_req, if_ack);
         end
      end
      d_req = 1'b1; d_we = 1'b0; d_addr = 30'h70;
      @(negedge clk);
      vectors++;
      if ({mem_req, owner, d_ack, if_ack} !== 4'b1110 || mem_addr !== 30'h70) begin
         miscompares++;
         $display("FAIL halt_data_served: req/own/dack/iack=%b%b%b%b addr=%h, want 1110 70",
                  mem_req, owner, d_ack, if_ack, mem_addr);
      end
      d_req = 1'b0;
      @(negedge clk);
      halt = 1'b0;
      vectors++;
      if (mem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL halt_idle: req=%b, want 0", mem_req);
      end
      @(negedge clk);
      vectors++;
      if ({mem_req, owner, if_ack} !== 3'b101 || mem_addr !== 30'h60) begin
         miscompares++;
         $display("FAIL unhalt_fetch: req/own/iack=%b%b%b addr=%h, want 101 60", mem_req, owner, if_ack, mem_addr);
      end
      if_req = 1'b0;
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      vectors++;
      if ({mem_req, if_ack} !== 2'b00) begin
         miscompares++;
         $display("FAIL unhalt_done: req/iack=%b%b, want 00", mem_req, if_ack);
      end
   endtask

   task automatic test_wait_states();
      d_req = 1'b1; d_we = 1'b1; d_addr = 30'h80; d_wdata = 32'hCAFEF00D;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         d_addr = 30'h80 + ADDR_W'(i + 1);
         d_wdata = 32'h1000 + DATA_W'(i);
         vectors++;
         if ({mem_req, mem_we, owner, d_ack} !== 4'b1110 || mem_addr !== 30'h80 || mem_wdata !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL wait_hold%0d: req/we/own/dack=%b%b%b%b addr=%h wdata=%h, want 1110 80 cafef00d",
                     i, mem_req, mem_we, owner, d_ack, mem_addr, mem_wdata);
         end
      end
      @(negedge clk);
      mem_ready = 1'b1; mem_rdata = 32'h55AA55AA;
      #1;
      vectors++;
      if (d_ack !== 1'b1 || d_rdata !== 32'h55AA55AA || mem_addr !== 30'h80) begin
         miscompares++;
         $display("FAIL wait_ack: dack=%b rdata=%h addr=%h, want 1 55aa55aa 80", d_ack, d_rdata, mem_addr);
      end
      d_req = 1'b0;
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      vectors++;
      if ({mem_req, d_ack} !== 2'b00) begin
         miscompares++;
         $display("FAIL wait_done: req/dack=%b%b, want 00", mem_req, d_ack);
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_store();
      test_contention();
      test_halt();
      test_wait_states();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end

endmodule
